motor_cmd_dispatch: RTL

// - Decodes the 16-bit SSP command stream into per-channel step-generator controls for NUM_MOTORS

---
 rtl/motor_cmd_pkg.sv | 18 +
 rtl/motor_cmd_dispatch_if.sv | 26 ++
 rtl/motor_chan_regs.sv | 41 ++++
 rtl/motor_cmd_dispatch.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/motor_cmd_pkg.sv
// rtl/motor_cmd_pkg.sv - shared constants and state encoding for the motor command dispatcher
package motor_cmd_pkg;

    localparam int WORD_W      = 16;
    localparam int HDR_IDX_LSB = 0;
    localparam int HDR_DIR_BIT = 4;
    localparam int DAT_ENA_BIT = 13;
    localparam int TYPE_BIT    = 15;

    // Header index that addresses every channel at once
    localparam logic [3:0] BCAST_IDX = 4'hF;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/motor_cmd_dispatch_if.sv
// rtl/motor_cmd_dispatch_if.sv - SSP word link between the serial port and the dispatcher
interface motor_cmd_dispatch_if;
    import motor_cmd_pkg::*;

    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [WORD_W-1:0] tx_word;
    logic              cmd_err;

    // SSP side drives received words and reads back the response word
    modport master (
        output word_valid,
        output word_data,
        input  tx_word,
        input  cmd_err
    );

    // Dispatcher side
    modport slave (
        input  word_valid,
        input  word_data,
        output tx_word,
        output cmd_err
    );

endinterface

// File: rtl/motor_chan_regs.sv
// rtl/motor_chan_regs.sv - divider/direction/enable registers for one motor channel
module motor_chan_regs #(
    parameter int DIV_W = 13
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             commit_en,
    input  logic [DIV_W-1:0] c_div,
    input  logic             c_dir,
    input  logic             c_ena,
    input  logic             limit_lo,
    output logic [DIV_W-1:0] divider,
    output logic             move_dir,
    output logic             step_ena
);

    logic nxt_dir;
    logic nxt_ena;

    // Post-commit view of direction/enable, used by the limit-stop rule
    always_comb begin
        nxt_dir = commit_en ? c_dir : move_dir;
        nxt_ena = commit_en ? c_ena : step_ena;
    end

    // Commit new settings; a set lower limit kills stepping toward it, even on the commit cycle
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            divider  <= '0;
            move_dir <= 1'b0;
            step_ena <= 1'b0;
        end else begin
            if (commit_en) begin
                divider <= c_div;
            end
            move_dir <= nxt_dir;
            step_ena <= nxt_ena & ~(limit_lo & ~nxt_dir);
        end
    end

endmodule

// File: rtl/motor_cmd_dispatch.sv
// rtl/motor_cmd_dispatch.sv - decodes two-word SSP commands into per-channel step controls
module motor_cmd_dispatch
    import motor_cmd_pkg::*;
#(
    parameter int NUM_MOTORS  = 10,
    parameter int DIV_W       = 13,
    parameter int POS_W       = 20,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    motor_cmd_dispatch_if.slave         ssp,
    input  logic [NUM_MOTORS*POS_W-1:0] cur_pos_flat,
    input  logic [NUM_MOTORS-1:0]       limit_lo,
    output logic [NUM_MOTORS*DIV_W-1:0] divider_flat,
    output logic [NUM_MOTORS-1:0]       move_dir,
    output logic [NUM_MOTORS-1:0]       step_ena
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [3:0]       NUM_IDX  = 4'(NUM_MOTORS);

    state_t             state;
    logic               wv_q;
    logic [3:0]         pend_idx;
    logic               pend_dir;
    logic [TMR_W-1:0]   timer;
    logic [3:0]         rb_idx;
    logic               rb_valid;

    logic               accept;
    logic               hdr_acc;
    logic               dat_acc;
    logic               commit_go;
    logic               pend_ok;
    logic               pend_bcast;
    logic [3:0]         hdr_idx;
    logic [3:0]         rb_sel;
    logic [WORD_W-1:0]  rb_word;
    logic [NUM_MOTORS-1:0] commit_en;
    logic               unused_bits;

    assign unused_bits = ^{ssp.word_data, cur_pos_flat};

    // Rising-edge accept, word classification and per-channel commit strobes
    always_comb begin
        accept     = ssp.word_valid & ~wv_q;
        hdr_acc    = accept & ~ssp.word_data[TYPE_BIT];
        dat_acc    = accept & ssp.word_data[TYPE_BIT];
        hdr_idx    = ssp.word_data[HDR_IDX_LSB +: 4];
        pend_bcast = (pend_idx == BCAST_IDX);
        pend_ok    = (pend_idx < NUM_IDX);
        commit_go  = (state == WAIT_DATA) && dat_acc;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            commit_en[i] = commit_go & (pend_bcast | (pend_idx == 4'(i)));
        end
    end

    // Readback word for the incoming header index, else for the last valid one
    always_comb begin
        rb_sel  = hdr_acc ? hdr_idx : rb_idx;
        rb_word = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (rb_sel == 4'(i)) begin
                rb_word = {limit_lo[i], cur_pos_flat[i*POS_W + POS_W-2 -: WORD_W-1]};
            end
        end
    end

    // Command FSM: header/data pairing, timeout and error pulse
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wv_q        <= 1'b0;
            pend_idx    <= '0;
            pend_dir    <= 1'b0;
            timer       <= '0;
            ssp.cmd_err <= 1'b0;
        end else begin
            wv_q        <= ssp.word_valid;
            ssp.cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_acc) begin
                        pend_idx <= hdr_idx;
                        pend_dir <= ssp.word_data[HDR_DIR_BIT];
                        timer    <= '0;
                        state    <= WAIT_DATA;
                    end else if (dat_acc) begin
                        ssp.cmd_err <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (hdr_acc) begin
                        pend_idx <= hdr_idx;
                        pend_dir <= ssp.word_data[HDR_DIR_BIT];
                        timer    <= '0;
                    end else if (dat_acc) begin
                        state <= IDLE;
                        if (!(pend_ok || pend_bcast)) begin
                            ssp.cmd_err <= 1'b1;
                        end
                    end else if (timer == TMR_LAST) begin
                        state       <= IDLE;
                        ssp.cmd_err <= 1'b1;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response word: position/limit of the addressed channel, or the limit bank
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ssp.tx_word <= '0;
            rb_idx      <= '0;
            rb_valid    <= 1'b0;
        end else if (hdr_acc) begin
            if (hdr_idx < NUM_IDX) begin
                ssp.tx_word <= rb_word;
                rb_idx      <= hdr_idx;
                rb_valid    <= 1'b1;
            end else begin
                ssp.tx_word <= WORD_W'(limit_lo);
                rb_valid    <= 1'b0;
            end
        end else if (state == IDLE && rb_valid) begin
            ssp.tx_word <= rb_word;
        end
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_chan
        motor_chan_regs #(
            .DIV_W (DIV_W)
        ) u_chan (
            .CLK       (CLK),
            .reset_n   (reset_n),
            .commit_en (commit_en[g]),
            .c_div     (ssp.word_data[DIV_W-1:0]),
            .c_dir     (pend_dir),
            .c_ena     (ssp.word_data[DAT_ENA_BIT]),
            .limit_lo  (limit_lo[g]),
            .divider   (divider_flat[g*DIV_W +: DIV_W]),
            .move_dir  (move_dir[g]),
            .step_ena  (step_ena[g])
        );
    end

endmodule
